vga_frame_buffer_db: RTL and testbench

VGA_FRAME_BUFFER_DB -- requirements
Module: vga_frame_buffer_db

---
 rtl/vga_frame_buffer_pkg.sv | 11 +
 rtl/vga_fb_dpram.sv | 51 +++++
 rtl/vga_frame_buffer_db.sv | 163 ++++++++++++++++
 tb/tb_vga_frame_buffer_db.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_frame_buffer_pkg.sv
// Shared types and constants for the double-buffered VGA frame buffer.
package vga_frame_buffer_pkg;

    localparam int unsigned READ_LAT = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_e;

endpackage

// File: rtl/vga_fb_dpram.sv
// Two-bank dual-port RAM: port A read/write (host and clear), port B read-only (scan).
// Both read ports register the address and then the data, giving a two-cycle latency.
module vga_fb_dpram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PIX_N  = 307200,
    parameter int unsigned ADDR_W = $clog2(PIX_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_we,
    input  logic              a_rd,
    input  logic [ADDR_W:0]   a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_rd,
    input  logic [ADDR_W:0]   b_addr,
    output logic [DATA_W-1:0] b_rdata
);

    logic [DATA_W-1:0] mem [2][PIX_N];
    logic [ADDR_W:0]   a_addr_q;
    logic [ADDR_W:0]   b_addr_q;
    logic              a_rd_q;
    logic              b_rd_q;

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr[ADDR_W]][a_addr[ADDR_W-1:0]] <= a_wdata;
        end
    end

    // Out-of-range reads arrive with the rd flag low and return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_addr_q <= '0;
            b_addr_q <= '0;
            a_rd_q   <= 1'b0;
            b_rd_q   <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_addr_q <= a_addr;
            b_addr_q <= b_addr;
            a_rd_q   <= a_rd;
            b_rd_q   <= b_rd;
            a_rdata  <= a_rd_q ? mem[a_addr_q[ADDR_W]][a_addr_q[ADDR_W-1:0]] : '0;
            b_rdata  <= b_rd_q ? mem[b_addr_q[ADDR_W]][b_addr_q[ADDR_W-1:0]] : '0;
        end
    end

endmodule

// File: rtl/vga_frame_buffer_db.sv
// Double-buffered frame buffer: host works on the back bank, scan-out reads the front bank,
// banks swap on vsync after a request. Optional clear engine under VGA_FRAME_BUFFER_CLEAR_EN.
module vga_frame_buffer_db
    import vga_frame_buffer_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned H_RES  = 640,
    parameter  int unsigned V_RES  = 480,
    localparam int unsigned PIX_N  = H_RES * V_RES,
    localparam int unsigned ADDR_W = $clog2(PIX_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              waitrequest,
    input  logic [ADDR_W-1:0] scan_address,
    input  logic              scan_read,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    input  logic              frame_start,
    input  logic              swap_req,
    output logic              swap_pending,
`ifdef VGA_FRAME_BUFFER_CLEAR_EN
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
`endif
    output logic              front_sel
);

    logic                accept;
    logic                host_wr;
    logic                host_rd;
    logic                host_in_range;
    logic                scan_in_range;
    logic                clearing;
    logic [ADDR_W-1:0]   clear_addr;
    logic [DATA_W-1:0]   color_q;
    logic                ram_we;
    logic [ADDR_W:0]     ram_a_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [READ_LAT-1:0] rd_pipe;
    logic [READ_LAT-1:0] scan_pipe;

    // Read and write together count as a write.
    assign accept        = chipselect & (read | write) & ~waitrequest;
    assign host_wr       = accept & write;
    assign host_rd       = accept & ~write;
    assign host_in_range = 32'(address) < PIX_N;
    assign scan_in_range = 32'(scan_address) < PIX_N;

`ifdef VGA_FRAME_BUFFER_CLEAR_EN
    clear_state_e      state;
    clear_state_e      state_next;
    logic [ADDR_W-1:0] clear_addr_next;
    logic [DATA_W-1:0] color_next;
    logic              busy_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            clear_addr  <= '0;
            color_q     <= '0;
            clear_busy  <= 1'b0;
            waitrequest <= 1'b0;
        end else begin
            state       <= state_next;
            clear_addr  <= clear_addr_next;
            color_q     <= color_next;
            clear_busy  <= busy_next;
            waitrequest <= busy_next;
        end
    end

    always_comb begin
        state_next      = state;
        clear_addr_next = clear_addr;
        color_next      = color_q;
        busy_next       = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next      = CLEAR;
                    clear_addr_next = '0;
                    color_next      = clear_color;
                    busy_next       = 1'b1;
                end
            end
            CLEAR: begin
                busy_next       = 1'b1;
                clear_addr_next = clear_addr + ADDR_W'(1);
                if (32'(clear_addr) == PIX_N - 1) begin
                    state_next      = IDLE;
                    clear_addr_next = '0;
                    busy_next       = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign clearing = (state == CLEAR);
`else
    assign clearing    = 1'b0;
    assign clear_addr  = '0;
    assign color_q     = '0;
    assign waitrequest = 1'b0;
`endif

    // A pending swap waits for vsync and for any clear to finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
        end else if (frame_start && swap_pending && !clearing) begin
            front_sel    <= ~front_sel;
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pipe   <= '0;
            scan_pipe <= '0;
        end else begin
            rd_pipe   <= {rd_pipe[READ_LAT-2:0], host_rd};
            scan_pipe <= {scan_pipe[READ_LAT-2:0], scan_read};
        end
    end

    assign readdatavalid = rd_pipe[READ_LAT-1];
    assign scan_valid    = scan_pipe[READ_LAT-1];

    assign ram_we     = clearing | (host_wr & host_in_range);
    assign ram_a_addr = {~front_sel, (clearing ? clear_addr : address)};
    assign ram_wdata  = clearing ? color_q : writedata;

    vga_fb_dpram #(
        .DATA_W (DATA_W),
        .PIX_N  (PIX_N),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .a_we    (ram_we),
        .a_rd    (host_rd & host_in_range),
        .a_addr  (ram_a_addr),
        .a_wdata (ram_wdata),
        .a_rdata (readdata),
        .b_rd    (scan_read & scan_in_range),
        .b_addr  ({front_sel, scan_address}),
        .b_rdata (scan_data)
    );

endmodule

// File: tb/tb_vga_frame_buffer_db.sv
// Directed bench for vga_frame_buffer_db; a smaller frame is used when VGA_FRAME_BUFFER_CLEAR_EN is set.
module tb_vga_frame_buffer_db;

`ifdef VGA_FRAME_BUFFER_CLEAR_EN
    localparam int unsigned H_RES = 64;
    localparam int unsigned V_RES = 48;
`else
    localparam int unsigned H_RES = 640;
    localparam int unsigned V_RES = 480;
`endif
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PIX_N  = H_RES * V_RES;
    localparam int unsigned ADDR_W = $clog2(PIX_N);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] address = '0;
    logic              chipselect = 1'b0;
    logic              write = 1'b0;
    logic              read = 1'b0;
    logic [DATA_W-1:0] writedata = '0;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;
    logic [ADDR_W-1:0] scan_address = '0;
    logic              scan_read = 1'b0;
    logic [DATA_W-1:0] scan_data;
    logic              scan_valid;
    logic              frame_start = 1'b0;
    logic              swap_req = 1'b0;
    logic              swap_pending;
    logic              front_sel;
`ifdef VGA_FRAME_BUFFER_CLEAR_EN
    logic              clear_req = 1'b0;
    logic [DATA_W-1:0] clear_color = '0;
    logic              clear_busy;
`endif

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    always #5 clk = ~clk;

    vga_frame_buffer_db #(
        .DATA_W (DATA_W),
        .H_RES  (H_RES),
        .V_RES  (V_RES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .chipselect    (chipselect),
        .write         (write),
        .read          (read),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .scan_address  (scan_address),
        .scan_read     (scan_read),
        .scan_data     (scan_data),
        .scan_valid    (scan_valid),
        .frame_start   (frame_start),
        .swap_req      (swap_req),
        .swap_pending  (swap_pending),
`ifdef VGA_FRAME_BUFFER_CLEAR_EN
        .clear_req     (clear_req),
        .clear_color   (clear_color),
        .clear_busy    (clear_busy),
`endif
        .front_sel     (front_sel)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int unsigned a, input logic [DATA_W-1:0] d);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = ADDR_W'(a); writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vec_cnt++;
        if (readdata !== '0 || readdatavalid !== 1'b0 || scan_data !== '0 || scan_valid !== 1'b0 ||
            waitrequest !== 1'b0 || swap_pending !== 1'b0 || front_sel !== 1'b0)
            $display("FAIL reset: rd=%0h rdv=%0b sd=%0h sv=%0b wr=%0b sp=%0b fs=%0b, want all 0",
                     readdata, readdatavalid, scan_data, scan_valid, waitrequest, swap_pending, front_sel);
`ifdef VGA_FRAME_BUFFER_CLEAR_EN
        vec_cnt++;
        if (clear_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_busy: clear_busy=%0b want 0", clear_busy);
        end
`endif
        if (readdata !== '0 || readdatavalid !== 1'b0 || scan_data !== '0 || scan_valid !== 1'b0 ||
            waitrequest !== 1'b0 || swap_pending !== 1'b0 || front_sel !== 1'b0)
            err_cnt++;
        reset = 1'b0;
        tick();
    endtask

    // Fill bank1[100] with 0x5A, then swap so bank1 is front.
    task automatic test_swap();
        host_write(100, 8'h5A);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        vec_cnt++;
        if (swap_pending !== 1'b1 || front_sel !== 1'b0) begin
            err_cnt++;
            $display("FAIL swap_set: pending=%0b front=%0b want 1/0", swap_pending, front_sel);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        vec_cnt++;
        if (front_sel !== 1'b1 || swap_pending !== 1'b0) begin
            err_cnt++;
            $display("FAIL swap_go: front=%0b pending=%0b want 1/0", front_sel, swap_pending);
        end
    endtask

    task automatic test_write_read();
        host_write(100, 8'hA5);
        chipselect = 1'b1; read = 1'b1; address = ADDR_W'(100);
        scan_read = 1'b1; scan_address = ADDR_W'(100);
        tick();
        chipselect = 1'b0; read = 1'b0; scan_read = 1'b0;
        vec_cnt++;
        if (readdatavalid !== 1'b0 || scan_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL lat_early: rdv=%0b sv=%0b want 0/0", readdatavalid, scan_valid);
        end
        tick();
        vec_cnt++;
        if (readdatavalid !== 1'b1 || readdata !== 8'hA5) begin
            err_cnt++;
            $display("FAIL rd_lat2: rdv=%0b rd=%0h want 1/a5", readdatavalid, readdata);
        end
        vec_cnt++;
        if (scan_valid !== 1'b1 || scan_data !== 8'h5A) begin
            err_cnt++;
            $display("FAIL scan_front: sv=%0b sd=%0h want 1/5a", scan_valid, scan_data);
        end
        tick();
        vec_cnt++;
        if (readdatavalid !== 1'b0 || scan_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL one_pulse: rdv=%0b sv=%0b want 0/0", readdatavalid, scan_valid);
        end
    endtask

    task automatic test_swap_back();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        vec_cnt++;
        if (front_sel !== 1'b0 || swap_pending !== 1'b0) begin
            err_cnt++;
            $display("FAIL swap_back: front=%0b pending=%0b want 0/0", front_sel, swap_pending);
        end
        scan_read = 1'b1; scan_address = ADDR_W'(100);
        tick();
        scan_read = 1'b0;
        tick();
        vec_cnt++;
        if (scan_valid !== 1'b1 || scan_data !== 8'hA5) begin
            err_cnt++;
            $display("FAIL scan_after_swap: sv=%0b sd=%0h want 1/a5", scan_valid, scan_data);
        end
    endtask

    task automatic test_same_cycle_swap();
        swap_req = 1'b1; frame_start = 1'b1;
        tick();
        swap_req = 1'b0; frame_start = 1'b0;
        vec_cnt++;
        if (front_sel !== 1'b0 || swap_pending !== 1'b1) begin
            err_cnt++;
            $display("FAIL same_cycle: front=%0b pending=%0b want 0/1", front_sel, swap_pending);
        end
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        vec_cnt++;
        if (front_sel !== 1'b1 || swap_pending !== 1'b0) begin
            err_cnt++;
            $display("FAIL next_frame: front=%0b pending=%0b want 1/0", front_sel, swap_pending);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_d [3];
        exp_d = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) host_write(i + 1, exp_d[i]);
        for (int k = 0; k < 6; k++) begin
            chipselect = (k < 3); read = (k < 3); address = ADDR_W'(k + 1);
            tick();
            vec_cnt++;
            if (k >= 1 && k <= 3) begin
                if (readdatavalid !== 1'b1 || readdata !== exp_d[k-1]) begin
                    err_cnt++;
                    $display("FAIL b2b[%0d]: rdv=%0b rd=%0h want 1/%0h", k, readdatavalid, readdata, exp_d[k-1]);
                end
            end else if (readdatavalid !== 1'b0) begin
                err_cnt++;
                $display("FAIL b2b_idle[%0d]: rdv=%0b want 0", k, readdatavalid);
            end
        end
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic test_read_and_write();
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = ADDR_W'(5); writedata = 8'h66;
        tick();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        tick();
        vec_cnt++;
        if (readdatavalid !== 1'b0) begin
            err_cnt++;
            $display("FAIL rw_as_write: rdv=%0b want 0", readdatavalid);
        end
        chipselect = 1'b1; read = 1'b1; address = ADDR_W'(5);
        tick();
        chipselect = 1'b0; read = 1'b0;
        tick();
        vec_cnt++;
        if (readdatavalid !== 1'b1 || readdata !== 8'h66) begin
            err_cnt++;
            $display("FAIL rw_readback: rdv=%0b rd=%0h want 1/66", readdatavalid, readdata);
        end
    endtask

    task automatic test_out_of_range();
        int unsigned addrs [3];
        logic [DATA_W-1:0] exp_d [3];
        addrs = '{0, PIX_N - 1, PIX_N};
        exp_d = '{8'h44, 8'h99, 8'h00};
        host_write(0, 8'h44);
        host_write(PIX_N - 1, 8'h99);
        host_write(PIX_N, 8'h77);
        for (int k = 0; k < 4; k++) begin
            chipselect = (k < 3); read = (k < 3); address = ADDR_W'(addrs[k % 3]);
            tick();
            if (k >= 1) begin
                vec_cnt++;
                if (readdatavalid !== 1'b1 || readdata !== exp_d[k-1]) begin
                    err_cnt++;
                    $display("FAIL range[%0d]: rdv=%0b rd=%0h want 1/%0h", k - 1, readdatavalid, readdata, exp_d[k-1]);
                end
            end
        end
        chipselect = 1'b0; read = 1'b0;
        tick();
    endtask

    // Read accepted on the swap cycle must come from the bank that was back at acceptance.
    task automatic test_inflight_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chipselect = 1'b1; read = 1'b1; address = ADDR_W'(100); frame_start = 1'b1;
        tick();
        chipselect = 1'b0; read = 1'b0; frame_start = 1'b0;
        vec_cnt++;
        if (front_sel !== 1'b0 || swap_pending !== 1'b0) begin
            err_cnt++;
            $display("FAIL inflight_swap: front=%0b pending=%0b want 0/0", front_sel, swap_pending);
        end
        tick();
        vec_cnt++;
        if (readdatavalid !== 1'b1 || readdata !== 8'hA5) begin
            err_cnt++;
            $display("FAIL inflight_data: rdv=%0b rd=%0h want 1/a5", readdatavalid, readdata);
        end
    endtask

    task automatic test_scan_pipeline();
        logic [DATA_W-1:0] exp_d [3];
        exp_d = '{8'h11, 8'h22, 8'h33};
        for (int k = 0; k < 6; k++) begin
            scan_read = (k < 3); scan_address = ADDR_W'(k + 1);
            tick();
            vec_cnt++;
            if (k >= 1 && k <= 3) begin
                if (scan_valid !== 1'b1 || scan_data !== exp_d[k-1]) begin
                    err_cnt++;
                    $display("FAIL scan_b2b[%0d]: sv=%0b sd=%0h want 1/%0h", k, scan_valid, scan_data, exp_d[k-1]);
                end
            end else if (scan_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL scan_idle[%0d]: sv=%0b want 0", k, scan_valid);
            end
        end
        scan_read = 1'b0;
    endtask

`ifdef VGA_FRAME_BUFFER_CLEAR_EN
    task automatic test_clear();
        int unsigned busy_cycles = 0;
        bit wr_bad = 1'b0;
        bit swap_bad = 1'b0;
        int unsigned addrs [3];
        addrs = '{0, 100, PIX_N - 1};
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        clear_req = 1'b1; clear_color = 8'h1F;
        tick();
        clear_req = 1'b0; clear_color = 8'h00;
        for (int i = 0; i < int'(PIX_N) + 8; i++) begin
            if (clear_busy !== 1'b1) break;
            busy_cycles++;
            if (waitrequest !== 1'b1) wr_bad = 1'b1;
            if (front_sel !== 1'b0) swap_bad = 1'b1;
            frame_start = (i == 3);
            clear_req = (i == 5); clear_color = 8'h22;
            tick();
        end
        frame_start = 1'b0; clear_req = 1'b0;
        vec_cnt++;
        if (busy_cycles != PIX_N || wr_bad || swap_bad) begin
            err_cnt++;
            $display("FAIL clear_busy: cycles=%0d wr_bad=%0b swap_bad=%0b want %0d/0/0",
                     busy_cycles, wr_bad, swap_bad, PIX_N);
        end
        vec_cnt++;
        if (swap_pending !== 1'b1 || waitrequest !== 1'b0 || front_sel !== 1'b0) begin
            err_cnt++;
            $display("FAIL clear_done: pending=%0b wr=%0b front=%0b want 1/0/0", swap_pending, waitrequest, front_sel);
        end
        for (int k = 0; k < 4; k++) begin
            chipselect = (k < 3); read = (k < 3); address = ADDR_W'(addrs[k % 3]);
            tick();
            if (k >= 1) begin
                vec_cnt++;
                if (readdatavalid !== 1'b1 || readdata !== 8'h1F) begin
                    err_cnt++;
                    $display("FAIL clear_data[%0d]: rdv=%0b rd=%0h want 1/1f", k - 1, readdatavalid, readdata);
                end
            end
        end
        chipselect = 1'b0; read = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        vec_cnt++;
        if (front_sel !== 1'b1 || swap_pending !== 1'b0) begin
            err_cnt++;
            $display("FAIL clear_swap: front=%0b pending=%0b want 1/0", front_sel, swap_pending);
        end
    endtask
`endif

    task automatic test_reset_mid();
`ifndef VGA_FRAME_BUFFER_CLEAR_EN
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
`endif
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        vec_cnt++;
        if (front_sel !== 1'b1 || swap_pending !== 1'b1) begin
            err_cnt++;
            $display("FAIL pre_reset: front=%0b pending=%0b want 1/1", front_sel, swap_pending);
        end
`ifdef VGA_FRAME_BUFFER_CLEAR_EN
        clear_req = 1'b1; clear_color = 8'h3C;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
`endif
        scan_read = 1'b1; scan_address = ADDR_W'(1);
        tick();
        scan_read = 1'b0;
        reset = 1'b1;
        tick();
        vec_cnt++;
        if (waitrequest !== 1'b0 || front_sel !== 1'b0 || swap_pending !== 1'b0 ||
            scan_valid !== 1'b0 || scan_data !== '0) begin
            err_cnt++;
            $display("FAIL reset_mid: wr=%0b front=%0b pending=%0b sv=%0b sd=%0h want 0/0/0/0/0",
                     waitrequest, front_sel, swap_pending, scan_valid, scan_data);
        end
`ifdef VGA_FRAME_BUFFER_CLEAR_EN
        vec_cnt++;
        if (clear_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_mid_busy: clear_busy=%0b want 0", clear_busy);
        end
`endif
        reset = 1'b0;
        tick();
`ifdef VGA_FRAME_BUFFER_CLEAR_EN
        vec_cnt++;
        if (clear_busy !== 1'b0 || waitrequest !== 1'b0) begin
            err_cnt++;
            $display("FAIL clear_aborted: busy=%0b wr=%0b want 0/0", clear_busy, waitrequest);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_swap();
        test_write_read();
        test_swap_back();
        test_same_cycle_swap();
        test_back_to_back();
        test_read_and_write();
        test_out_of_range();
        test_inflight_swap();
        test_scan_pipeline();
`ifdef VGA_FRAME_BUFFER_CLEAR_EN
        test_clear();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
